// File: rtl/multu_sequencer_if.sv
// Bundle of decoder-driven controls and HI/LO-side results for the MULTU sequencer.
interface multu_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             rd_hi;
   logic             rd_lo;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             stall;

   // Decoder / pipeline side
   modport master (
      output start, srca, srcb, rd_hi, rd_lo, wr_hi, wr_lo, wdata,
      input  hi, lo, busy, done, stall
   );

   // Sequencer side
   modport slave (
      input  start, srca, srcb, rd_hi, rd_lo, wr_hi, wr_lo, wdata,
      output hi, lo, busy, done, stall
   );
endinterface

// File: rtl/multu_sequencer.sv
// Shift-add unsigned multiplier owning the architectural HI/LO pair.
// Consumes STEP multiplier bits per RUN cycle and commits the full product on the last one.
module multu_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 1
) (
   input logic                clk,
   input logic                reset,
   multu_sequencer_if.slave   bus
);

   localparam int unsigned NCYC  = WIDTH / STEP;
   localparam int unsigned CNT_W = $clog2(NCYC + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic [2*WIDTH-1:0] pp;
   logic [2*WIDTH-1:0] acc_sum;
   int unsigned        shamt;

   // Partial product of this RUN cycle, placed at the offset of the bits already consumed
   always_comb begin
      pp      = {{WIDTH{1'b0}}, mcand_q} * {{(2*WIDTH-STEP){1'b0}}, mplier_q[STEP-1:0]};
      shamt   = STEP * (NCYC - 32'(cnt_q));
      acc_sum = acc_q + (pp << shamt);
   end

   // Next-state: IDLE and DONE decode identically; start outranks MTHI/MTLO
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         RUN: begin
            acc_d    = acc_sum;
            mplier_d = mplier_q >> STEP;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = acc_sum[2*WIDTH-1:WIDTH];
               lo_d    = acc_sum[WIDTH-1:0];
               state_d = DONE;
            end
         end
         default: begin
            if (bus.start) begin
               mcand_d  = bus.srca;
               mplier_d = bus.srcb;
               acc_d    = '0;
               cnt_d    = CNT_W'(NCYC);
               state_d  = RUN;
            end else begin
               state_d = IDLE;
               if (bus.wr_hi) hi_d = bus.wdata;
               if (bus.wr_lo) lo_d = bus.wdata;
            end
         end
      endcase
   end

   // State registers; reset aborts a running multiply without committing
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.busy  = (state_q == RUN);
   assign bus.done  = (state_q == DONE);
   // Any HI/LO access or new MULTU must wait for the running product
   assign bus.stall = bus.busy & (bus.start | bus.rd_hi | bus.rd_lo | bus.wr_hi | bus.wr_lo);

endmodule

// File: tb/tb_multu_sequencer.sv
// Directed bench for multu_sequencer: table of products plus hand-written multi-cycle sequences.
module tb_multu_sequencer;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   logic [31:0] m_hi;
   logic [31:0] m_lo;

   multu_sequencer_if #(.WIDTH(32)) bus1 ();
   multu_sequencer_if #(.WIDTH(32)) bus4 ();

   multu_sequencer #(.WIDTH(32), .STEP(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   multu_sequencer #(.WIDTH(32), .STEP(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue MULTU now (at posedge+1), scramble operands afterwards, follow it to the done cycle.
   // With chain set the task returns while still in the done cycle.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eh,
                          input logic [31:0] el, input string name, input bit chain);
      int n;
      bus1.srca  = a;
      bus1.srcb  = b;
      bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      bus1.wr_hi = 1'b0;
      bus1.wr_lo = 1'b0;
      bus1.srca  = ~a;
      bus1.srcb  = ~b;
      chk({name, " hold_hilo"}, {bus1.hi, bus1.lo}, {m_hi, m_lo});
      n = 0;
      while (bus1.busy === 1'b1 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      chk({name, " busy_cycles"}, 64'(n), 64'd32);
      chk({name, " done"}, 64'(bus1.done), 64'd1);
      chk({name, " hilo"}, {bus1.hi, bus1.lo}, {eh, el});
      m_hi = eh;
      m_lo = el;
      if (!chain) begin
         @(posedge clk); #1;
         chk({name, " done_drop"}, 64'({bus1.done, bus1.busy}), 64'd0);
      end
   endtask

   initial begin
      int stall_bad;
      int done_seen;
      int n;
      checks   = 0;
      failures = 0;
      m_hi     = '0;
      m_lo     = '0;

      bus1.start = 0; bus1.srca = 0; bus1.srcb = 0; bus1.rd_hi = 0; bus1.rd_lo = 0;
      bus1.wr_hi = 0; bus1.wr_lo = 0; bus1.wdata = 0;
      bus4.start = 0; bus4.srca = 0; bus4.srcb = 0; bus4.rd_hi = 0; bus4.rd_lo = 0;
      bus4.wr_hi = 0; bus4.wr_lo = 0; bus4.wdata = 0;

      vecs[0] = '{a: 32'd3,          b: 32'd5,          hi: 32'h0000_0000, lo: 32'h0000_000F};
      vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  hi: 32'hFFFF_FFFE, lo: 32'h0000_0001};
      vecs[2] = '{a: 32'h0000_0000,  b: 32'h1234_5678,  hi: 32'h0000_0000, lo: 32'h0000_0000};
      vecs[3] = '{a: 32'h8000_0000,  b: 32'd2,          hi: 32'h0000_0001, lo: 32'h0000_0000};
      vecs[4] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          hi: 32'h0000_0001, lo: 32'hFFFF_FFFE};
      vecs[5] = '{a: 32'h1234_5678,  b: 32'h10,         hi: 32'h0000_0001, lo: 32'h2345_6780};
      vecs[6] = '{a: 32'hDEAD_BEEF,  b: 32'd1,          hi: 32'h0000_0000, lo: 32'hDEAD_BEEF};

      // Reset state
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset hilo", {bus1.hi, bus1.lo}, 64'd0);
      chk("reset flags", 64'({bus1.busy, bus1.done, bus1.stall}), 64'd0);
      reset = 1'b0;

      // Table-driven products
      for (int i = 0; i < 7; i++) begin
         run_mul(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i), 1'b0);
      end

      // MFLO held from cycle 5 stalls through cycle 32; MTLO during RUN is dropped
      bus1.srca  = 32'h0001_0001;
      bus1.srcb  = 32'h0001_0001;
      bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus1.rd_lo = 1'b1;
      #1;
      stall_bad = 0;
      for (int c = 5; c <= 32; c++) begin
         if (!(bus1.stall === 1'b1 && bus1.busy === 1'b1)) stall_bad++;
         if (c == 20) begin
            bus1.wr_lo = 1'b1;
            bus1.wdata = 32'hFFFF_FFFF;
         end
         if (c == 21) begin
            bus1.wr_lo = 1'b0;
            chk("busy wr_lo ignored", 64'(bus1.lo), 64'(m_lo));
         end
         @(posedge clk); #2;
      end
      chk("stall window", 64'(stall_bad), 64'd0);
      chk("stall released", 64'({bus1.stall, bus1.done}), 64'b01);
      chk("rd_lo product", {bus1.hi, bus1.lo}, {32'h0000_0001, 32'h0002_0001});
      bus1.rd_lo = 1'b0;
      m_hi = 32'h0000_0001;
      m_lo = 32'h0002_0001;

      // Reset in RUN cycle 10 aborts: no commit, no done pulse
      @(posedge clk); #1;
      bus1.srca  = 32'd5;
      bus1.srcb  = 32'd7;
      bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("pre-abort busy", 64'(bus1.busy), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort flags", 64'({bus1.busy, bus1.done}), 64'd0);
      chk("abort hilo", {bus1.hi, bus1.lo}, 64'd0);
      m_hi = '0;
      m_lo = '0;
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus1.done === 1'b1 || bus1.busy === 1'b1) done_seen++;
         @(posedge clk); #1;
      end
      chk("abort no done", 64'(done_seen), 64'd0);

      // Back-to-back: second MULTU issued in the done cycle of the first
      run_mul(32'd7, 32'd9, 32'd0, 32'd63, "chain1", 1'b1);
      run_mul(32'd2, 32'd2, 32'd0, 32'd4, "chain2", 1'b0);

      // MTHI, then MTHI+MTLO together, then MFHI while idle
      bus1.wr_hi = 1'b1;
      bus1.wdata = 32'd1234;
      @(posedge clk); #1;
      bus1.wr_hi = 1'b0;
      chk("mthi", {bus1.hi, bus1.lo}, {32'd1234, 32'd4});
      bus1.wr_hi = 1'b1;
      bus1.wr_lo = 1'b1;
      bus1.wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      bus1.wr_hi = 1'b0;
      bus1.wr_lo = 1'b0;
      chk("mthi+mtlo", {bus1.hi, bus1.lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
      m_hi = 32'hCAFE_F00D;
      m_lo = 32'hCAFE_F00D;
      bus1.rd_hi = 1'b1;
      #1;
      chk("idle rd_hi no stall", 64'(bus1.stall), 64'd0);
      bus1.rd_hi = 1'b0;
      @(posedge clk); #1;

      // start and MTHI/MTLO together: start wins, HI/LO untouched until commit
      bus1.wr_hi = 1'b1;
      bus1.wr_lo = 1'b1;
      bus1.wdata = 32'h0;
      run_mul(32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, "start_vs_wr", 1'b0);

      // STEP=4 instance: 8 busy cycles, done in cycle 9
      bus4.srca  = 32'h0001_0000;
      bus4.srcb  = 32'h0001_0000;
      bus4.start = 1'b1;
      @(posedge clk); #1;
      bus4.start = 1'b0;
      bus4.srca  = 32'hFFFF_FFFF;
      bus4.srcb  = 32'hFFFF_FFFF;
      n = 0;
      while (bus4.busy === 1'b1 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      chk("step4 busy_cycles", 64'(n), 64'd8);
      chk("step4 done", 64'(bus4.done), 64'd1);
      chk("step4 hilo", {bus4.hi, bus4.lo}, {32'h0000_0001, 32'h0000_0000});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
